// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding and counter sizing helper.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divider_sub_unit.sv
// Borrow-out subtractor for one restoring-division step (data_len+1-bit operands).
// Latency: combinational.
// Backpressure: none.
module sub_unit #(
    parameter int data_len = 32
) (
    input  logic [data_len:0]   a,
    input  logic [data_len:0]   b,
    output logic [data_len-1:0] diff,
    output logic                borrow
);

    // Only the low bits of a difference are ever kept, since a kept difference is below the divisor.
    assign borrow = (a < b);
    assign diff   = a[data_len-1:0] - b[data_len-1:0];

endmodule

// File: rtl/divider.sv
// Multicycle restoring divider, one quotient bit per cycle; DIVIDER_SIGNED_EN adds is_signed.
// Latency: data_len+1 cycles from accept to out_valid (1 cycle for a zero divisor).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module divider
    import divider_pkg::*;
#(
    parameter int data_len = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
`ifdef DIVIDER_SIGNED_EN
    input  logic                is_signed,
`endif
    input  logic [data_len-1:0] dividend,
    input  logic [data_len-1:0] divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [data_len-1:0] quotient,
    output logic [data_len-1:0] remainder
);

    localparam int cw = cnt_w(data_len);

    state_t              state, state_nxt;
    logic [cw-1:0]       cnt;
    logic [data_len-1:0] part, quo, dvs;
    logic [data_len-1:0] dnd_mag, dvs_mag;
    logic [data_len-1:0] part_nxt, quo_nxt, diff;
    logic [data_len-1:0] q_res, r_res;
    logic [data_len:0]   shifted;
    logic                borrow, last, accept, div_zero;

    assign accept   = in_valid && (state == IDLE);
    assign div_zero = (divisor == '0);
    assign last     = (cnt == cw'(data_len - 1));

`ifdef DIVIDER_SIGNED_EN
    logic dnd_neg, dvs_neg, neg_q, neg_r;

    // Divide magnitudes, then fix signs: quotient by sign difference, remainder follows dividend.
    assign dnd_neg = is_signed && dividend[data_len-1];
    assign dvs_neg = is_signed && divisor[data_len-1];
    assign dnd_mag = dnd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
    assign q_res   = neg_q ? -quo_nxt : quo_nxt;
    assign r_res   = neg_r ? -part_nxt : part_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dnd_neg ^ dvs_neg;
            neg_r <= dnd_neg;
        end
    end
`else
    assign dnd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_res   = quo_nxt;
    assign r_res   = part_nxt;
`endif

    assign shifted = {part, quo[data_len-1]};

    sub_unit #(.data_len(data_len)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign part_nxt = borrow ? shifted[data_len-1:0] : diff;
    assign quo_nxt  = {quo[data_len-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = div_zero ? DONE : BUSY;
            end
            BUSY: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            part      <= '0;
            quo       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cnt  <= '0;
                    part <= '0;
                    quo  <= dnd_mag;
                    dvs  <= dvs_mag;
                    if (div_zero) begin
                        quotient  <= '1;
                        remainder <= dividend;
                    end
                end
                BUSY: begin
                    cnt  <= last ? '0 : cnt + 1'b1;
                    part <= part_nxt;
                    quo  <= quo_nxt;
                    if (last) begin
                        quotient  <= q_res;
                        remainder <= r_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider at data_len=8: stimulus pushes expected results, a monitor pops on each handshake.
module tb_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient, remainder;
`ifdef DIVIDER_SIGNED_EN
    logic         is_signed = 1'b0;
`endif

    always #5 clk = ~clk;

    divider #(.data_len(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef DIVIDER_SIGNED_EN
        .is_signed (is_signed),
`endif
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a result transfers on the edge following a negedge with out_valid && out_ready.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got q=%0d r=%0d, expected no result", quotient, remainder);
            end else begin
                e = sb.pop_front();
                check({e.name, "_quotient"}, {24'b0, quotient}, {24'b0, e.q});
                check({e.name, "_remainder"}, {24'b0, remainder}, {24'b0, e.r});
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef DIVIDER_SIGNED_EN
        is_signed = sgn;
`else
        if (sgn) $display("note: signed operation requested in unsigned build");
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = b ^ 8'h5A;
    endtask

    task automatic send(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int exp_lat, input logic noise);
        int lat;
        sb.push_back('{name, eq, er});
        issue(a, b, sgn);
        if (noise) in_valid = 1'b1;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        if (noise) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        #3;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_quotient", {24'b0, quotient}, 32'd0);
        check("reset_remainder", {24'b0, remainder}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send("d100_7",   8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   9, 1'b0);
        send("d37_0",    8'd37,  8'd0,   1'b0, 8'd255, 8'd37,  1, 1'b0);
        send("d5_9",     8'd5,   8'd9,   1'b0, 8'd0,   8'd5,   9, 1'b0);
        send("d255_1",   8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   9, 1'b1);
        send("d254_16",  8'd254, 8'd16,  1'b0, 8'd15,  8'd14,  9, 1'b0);
        send("d255_255", 8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   9, 1'b0);
        send("d0_5",     8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   9, 1'b0);

        // Consumer stall: result must hold for five DONE cycles with input side closed.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send("stall_100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 9, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_quotient", {24'b0, quotient}, 32'd14);
            check("stall_remainder", {24'b0, remainder}, 32'd2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_out_valid", {31'b0, out_valid}, 32'd0);

        // Reset in the middle of BUSY must discard the operation.
        issue(8'd50, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_quotient", {24'b0, quotient}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_result", seen, 32'd0);
        send("d200_3", 8'd200, 8'd3, 1'b0, 8'd66, 8'd2, 9, 1'b0);

`ifdef DIVIDER_SIGNED_EN
        send("s_m7_2",    8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 9, 1'b0);
        send("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 9, 1'b0);
        send("s_m7_0",    8'hF9, 8'h00, 1'b1, 8'hFF, 8'hF9, 1, 1'b0);
        send("s_7_m2",    8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 9, 1'b0);
        send("u_249_2",   8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 9, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter data_len, default 32: operand and result width in bits, minimum 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands present.
REQ-005 SHALL have port in_ready, output, 1 bit: divider can accept operands.
REQ-006 SHALL have port dividend, input, data_len bits.
REQ-007 SHALL have port divisor, input, data_len bits.
REQ-008 SHALL have port out_valid, output, 1 bit: result present.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port quotient, output, data_len bits.
REQ-011 SHALL have port remainder, output, data_len bits.
REQ-012 SHALL have port is_signed, input, 1 bit, present only with DIVIDER_SIGNED_EN: operands are two's complement.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready high only in IDLE, and out_valid high only in DONE.
REQ-015 SHALL capture operands when in_valid and in_ready are both high at a clk edge, then move IDLE to BUSY.
REQ-016 SHALL, in BUSY, run restoring division: one quotient bit per cycle, MSB first, for exactly data_len cycles (iteration counter 0 to data_len-1), then move to DONE.
REQ-017 SHALL compute each iteration as partial remainder shifted left with the next dividend bit, minus divisor, using a data_len+1-bit subtraction; keep the difference and set the quotient bit to 1 if there is no borrow, else restore and set the bit to 0.
REQ-018 SHALL make out_valid rise exactly data_len+1 cycles after the accepting edge.
REQ-019 SHALL, on a zero divisor, skip BUSY and go IDLE to DONE in one cycle with quotient all ones and remainder equal to dividend.
REQ-020 SHALL hold quotient and remainder stable while in DONE, and move DONE to IDLE on the edge where out_ready is high.
REQ-021 SHALL ignore in_valid outside IDLE; operands SHALL NOT change mid-operation.
REQ-022 SHALL make quotient and remainder unsigned results of the captured operands.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force state IDLE, counter 0, and quotient and remainder 0; in_ready SHALL be 1 and out_valid 0.
REQ-024 SHALL abort any BUSY or DONE operation on reset; no result SHALL be presented afterwards.

Configuration
REQ-025 SHALL support macro DIVIDER_SIGNED_EN.
- Defined: is_signed port exists. When is_signed is high:
  - Operands are converted to magnitudes on capture.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Most-negative divided by -1 gives quotient = dividend, remainder 0.
  - Divide-by-zero behaves as in REQ-019, with the raw dividend.
- Undefined: no is_signed port; unsigned only; no sign logic is synthesised.

Structure
REQ-026 SHALL put the FSM state encoding typedef in the shared package, with constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
REQ-027 SHALL isolate the borrow-out subtraction in sub-module sub_unit (parameter data_len; ports a, b, diff, borrow).

Verification (data_len=8)
REQ-028 SHALL cover: 100/7 accepted -> out_valid after exactly 9 cycles with quotient 14, remainder 2.
REQ-029 SHALL cover: 37/0 -> out_valid on the next cycle with quotient 255, remainder 37.
REQ-030 SHALL cover: 5/9 -> quotient 0, remainder 5; then 255/1 -> quotient 255, remainder 0.
REQ-031 SHALL cover: out_ready held low for 5 cycles in DONE -> results stable and in_ready low throughout; out_ready high -> IDLE next cycle.
REQ-032 SHALL cover: rst_n pulsed low in BUSY -> state IDLE, out_valid stays 0, and the next operation 200/3 gives quotient 66, remainder 2.
REQ-033 SHALL cover, with DIVIDER_SIGNED_EN: -7/2 -> quotient -3, remainder -1; -128/-1 -> quotient -128, remainder 0.
